// File: rtl/button_press_classifier.sv
// ============================================================================
//  Module      : button_press_classifier
//  Description : Synchronizes and debounces a raw button pin, then classifies
//                gestures into short, long and double press pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module button_press_classifier #(
    parameter int DEBOUNCE_CLOCK_PERIODS   = 16000,
    parameter int LONG_PRESS_CLOCK_PERIODS = 8000000,
    parameter int DOUBLE_GAP_CLOCK_PERIODS = 4000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_raw,
    output logic       button_stable,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic [7:0] event_count
);

    localparam int c_max_periods = (LONG_PRESS_CLOCK_PERIODS > DOUBLE_GAP_CLOCK_PERIODS) ?
                                   LONG_PRESS_CLOCK_PERIODS : DOUBLE_GAP_CLOCK_PERIODS;
    localparam int c_timer_width = $clog2(c_max_periods + 1);
    localparam int c_deb_width   = $clog2(DEBOUNCE_CLOCK_PERIODS + 1);

    localparam logic [c_timer_width-1:0] c_timer_max = '1;
    localparam logic [c_timer_width-1:0] c_long_last = c_timer_width'(LONG_PRESS_CLOCK_PERIODS - 1);
    localparam logic [c_timer_width-1:0] c_gap_last  = c_timer_width'(DOUBLE_GAP_CLOCK_PERIODS - 1);
    localparam logic [c_deb_width-1:0]   c_deb_last  = c_deb_width'(DEBOUNCE_CLOCK_PERIODS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED1  = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_GAP  = 3'd3,
        PRESSED2  = 3'd4
    } state_t;

    state_t                   r_state;
    logic                     r_sync_meta;
    logic                     r_sync;
    logic [c_deb_width-1:0]   r_deb_cnt;
    logic [c_timer_width-1:0] r_timer;

    logic                     w_toggle;
    logic                     w_rise;
    logic                     w_fall;
    logic [c_timer_width-1:0] w_timer_next;

    // Edge events coincide with the cycle button_stable changes, so the timer
    // restarts at the same edge and counts cycles of the new level directly.
    assign w_toggle     = (r_sync != button_stable) && (r_deb_cnt == c_deb_last);
    assign w_rise       = w_toggle && !button_stable;
    assign w_fall       = w_toggle &&  button_stable;
    assign w_timer_next = (r_timer == c_timer_max) ? r_timer : r_timer + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync_meta   <= 1'b0;
            r_sync        <= 1'b0;
            r_deb_cnt     <= '0;
            button_stable <= 1'b0;
        end else begin
            r_sync_meta <= button_raw;
            r_sync      <= r_sync_meta;
            if (r_sync == button_stable) begin
                r_deb_cnt <= '0;
            end else if (w_toggle) begin
                r_deb_cnt     <= '0;
                button_stable <= ~button_stable;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            event_count  <= 8'd0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            r_timer      <= w_timer_next;
            if (short_press || long_press || double_press) begin
                event_count <= event_count + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESSED1;
                        r_timer <= '0;
                    end
                end
                PRESSED1: begin
                    if (r_timer == c_long_last) begin
                        long_press <= 1'b1;
                        r_state    <= LONG_HELD;
                    end else if (w_fall) begin
                        r_state <= WAIT_GAP;
                        r_timer <= '0;
                    end
                end
                LONG_HELD: begin
                    if (!button_stable) begin
                        r_state <= IDLE;
                    end
                end
                WAIT_GAP: begin
                    // A rise landing on the expiry edge starts a fresh gesture.
                    if (r_timer == c_gap_last) begin
                        short_press <= 1'b1;
                        r_state     <= w_rise ? PRESSED1 : IDLE;
                        r_timer     <= '0;
                    end else if (w_rise) begin
                        r_state <= PRESSED2;
                        r_timer <= '0;
                    end
                end
                PRESSED2: begin
                    if (!button_stable) begin
                        double_press <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_press_classifier.sv
// ============================================================================
//  Module      : tb_button_press_classifier
//  Description : Directed scoreboard bench for button_press_classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_press_classifier;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int GAP  = 10;
    // Raw edge to button_stable edge: two sync flops plus debounce.
    localparam int LAT  = 2 + DEB;

    localparam logic [2:0] K_SHORT  = 3'b001;
    localparam logic [2:0] K_LONG   = 3'b010;
    localparam logic [2:0] K_DOUBLE = 3'b100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button_raw = 1'b0;
    logic       button_stable;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic [7:0] event_count;

    button_press_classifier #(
        .DEBOUNCE_CLOCK_PERIODS  (DEB),
        .LONG_PRESS_CLOCK_PERIODS(LONG),
        .DOUBLE_GAP_CLOCK_PERIODS(GAP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_raw   (button_raw),
        .button_stable(button_stable),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .event_count  (event_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] kind;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clock) begin
        logic [2:0] p;
        p = {double_press, long_press, short_press};
        if (p != 3'b000) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got pulses=%b at cycle %0d, required none", p, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (p != mon_e.kind || cyc != mon_e.at) begin
                    n_err++;
                    $display("FAIL pulse_match: got pulses=%b at cycle %0d, required %b at cycle %0d",
                             p, cyc, mon_e.kind, mon_e.at);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            n_cmp++;
            n_err++;
            mon_e = exp_q.pop_front();
            $display("FAIL pulse_missing: got no pulse by cycle %0d, required %b at cycle %0d",
                     cyc, mon_e.kind, mon_e.at);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        button_raw = 1'b0;
        ticks(3);
        reset = 1'b0;
        ticks(2);
    endtask

    task automatic short_seq();
        button_raw = 1'b1;
        ticks(8);
        button_raw = 1'b0;
        exp_q.push_back('{K_SHORT, cyc + LAT + GAP});
        ticks(20);
    endtask

    initial begin
        int c0;
        logic seen;

        // Reset with the button already held.
        reset      = 1'b1;
        button_raw = 1'b1;
        @(negedge clock);
        ticks(3);
        check("reset_stable", button_stable, 0);
        check("reset_count", event_count, 0);
        check("reset_pulses", {double_press, long_press, short_press}, 0);
        reset = 1'b0;
        ticks(LAT - 1);
        check("held_stable_early", button_stable, 0);
        ticks(1);
        check("held_stable_rise", button_stable, 1);

        // Glitch shorter than the debounce window.
        do_reset();
        button_raw = 1'b1;
        ticks(3);
        button_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            seen = seen | button_stable;
        end
        check("glitch_stable", seen, 0);

        // Short press.
        do_reset();
        button_raw = 1'b1;
        ticks(LAT - 1);
        check("short_stable_pre", button_stable, 0);
        ticks(1);
        check("short_stable_rise", button_stable, 1);
        ticks(8 - LAT);
        button_raw = 1'b0;
        c0 = cyc;
        exp_q.push_back('{K_SHORT, c0 + LAT + GAP});
        ticks(LAT);
        check("short_stable_fall", button_stable, 0);
        ticks(14);
        check("short_count", event_count, 1);

        // Long press held 30 cycles.
        do_reset();
        button_raw = 1'b1;
        exp_q.push_back('{K_LONG, cyc + LAT + LONG});
        ticks(30);
        button_raw = 1'b0;
        ticks(20);
        check("long_count", event_count, 1);

        // Double press: two 6-cycle presses with a 5-cycle gap.
        do_reset();
        button_raw = 1'b1;
        ticks(6);
        button_raw = 1'b0;
        ticks(5);
        button_raw = 1'b1;
        ticks(6);
        button_raw = 1'b0;
        exp_q.push_back('{K_DOUBLE, cyc + LAT + 1});
        ticks(20);
        check("double_count", event_count, 1);

        // Reset during the gap discards the pending short press.
        do_reset();
        button_raw = 1'b1;
        ticks(8);
        button_raw = 1'b0;
        ticks(8);
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(20);
        check("gap_reset_count", event_count, 0);

        // Counter wrap over 256 short presses.
        for (int i = 0; i < 256; i++) begin
            short_seq();
            if (i == 127) check("wrap_count_mid", event_count, 128);
        end
        check("wrap_count_final", event_count, 0);

        ticks(30);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion by cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
